// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential-multiplier front end.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // BUSY cycles allowed before an unresponsive multiplier is abandoned
  function automatic int TIMEOUT_CYCLES(input int n);
    return 2 * n + 4;
  endfunction

endpackage

// File: rtl/seq_mult_fifo.sv
// Operand-pair FIFO: stores {a,b} as 2N-bit words, DEPTH entries, pointers wrap modulo DEPTH.
module seq_mult_fifo #(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [2*N-1:0]         wr_data,
  output logic [2*N-1:0]         rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [2*N-1:0] mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [AW:0]    count_r;
  logic           push_s;
  logic           pop_s;

  assign push_s  = push & ~full;
  assign pop_s   = pop & ~empty;
  assign full    = (count_r == FULL_COUNT);
  assign empty   = (count_r == {(AW + 1){1'b0}});
  assign count   = count_r;
  assign rd_data = mem_r[rd_ptr_r];

  // Storage array and write pointer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {(2 * N){1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
      wr_ptr_r        <= wr_ptr_r + AW'(1);
    end
  end

  // Read pointer and occupancy count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else begin
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/seq_mult_frontend.sv
// Operand-issue / result-capture stage around the N-bit sequential multiplier.
// Optional output timeout enabled by defining SEQ_MULT_FE_TIMEOUT_EN.
module seq_mult_frontend
  import seq_mult_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           in_a,
  input  logic [N-1:0]           in_b,
  output logic                   mul_start,
  output logic [N-1:0]           mul_multiplicand,
  output logic [N-1:0]           mul_multiplier,
  input  logic                   mul_ready,
  input  logic [2*N-1:0]         mul_product,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*N-1:0]         out_product,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef SEQ_MULT_FE_TIMEOUT_EN
  ,
  output logic                   timeout
`endif
);

  state_t         state_r;
  logic           seen_low_r;
  logic           out_valid_r;
  logic           busy_r;
  logic [2*N-1:0] out_product_r;
  logic [2*N-1:0] head_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;
  logic           issue_s;

`ifdef SEQ_MULT_FE_TIMEOUT_EN
  localparam int TO_LIMIT = TIMEOUT_CYCLES(N);
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);

  logic [TO_W-1:0] to_cnt_r;
  logic            timeout_r;

  assign timeout = timeout_r;
`endif

  seq_mult_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (in_valid),
    .pop     (issue_s),
    .wr_data ({in_a, in_b}),
    .rd_data (head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count)
  );

  assign in_ready                          = ~fifo_full_s;
  assign {mul_multiplicand, mul_multiplier} = head_s;
  assign issue_s     = (state_r == IDLE) & ~fifo_empty_s & mul_ready;
  assign mul_start   = issue_s;
  assign out_valid   = out_valid_r;
  assign out_product = out_product_r;
  assign busy        = busy_r;

  // Issue/complete/respond sequencer; completion needs mul_ready to have dropped first
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      seen_low_r    <= 1'b0;
      out_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
      out_product_r <= {(2 * N){1'b0}};
`ifdef SEQ_MULT_FE_TIMEOUT_EN
      to_cnt_r      <= {TO_W{1'b0}};
      timeout_r     <= 1'b0;
`endif
    end else begin
`ifdef SEQ_MULT_FE_TIMEOUT_EN
      timeout_r <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (issue_s) begin
            state_r    <= BUSY;
            seen_low_r <= 1'b0;
            busy_r     <= 1'b1;
`ifdef SEQ_MULT_FE_TIMEOUT_EN
            to_cnt_r   <= {TO_W{1'b0}};
`endif
          end
        end
        BUSY: begin
          if (!mul_ready) begin
            seen_low_r <= 1'b1;
          end
          if (seen_low_r && mul_ready) begin
            out_product_r <= mul_product;
            out_valid_r   <= 1'b1;
            state_r       <= RESP;
          end
`ifdef SEQ_MULT_FE_TIMEOUT_EN
          else if (to_cnt_r == TO_LAST) begin
            out_product_r <= {(2 * N){1'b1}};
            out_valid_r   <= 1'b1;
            timeout_r     <= 1'b1;
            state_r       <= RESP;
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
          end
`endif
        end
        RESP: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_frontend.sv
// Directed bench for seq_mult_frontend with a behavioural sequential multiplier attached.
module tb_seq_mult_frontend;

  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       mul_start;
  logic [3:0] mul_multiplicand;
  logic [3:0] mul_multiplier;
  logic       mul_ready;
  logic [7:0] mul_product;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_product;
  logic       busy;
  logic [2:0] fifo_count;
`ifdef SEQ_MULT_FE_TIMEOUT_EN
  logic       timeout;
`endif

  always #5 clock = ~clock;

  seq_mult_frontend #(.N(N), .DEPTH(DEPTH)) dut (
    .clock            (clock),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_a             (in_a),
    .in_b             (in_b),
    .mul_start        (mul_start),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_ready        (mul_ready),
    .mul_product      (mul_product),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_product      (out_product),
    .busy             (busy),
    .fifo_count       (fifo_count)
`ifdef SEQ_MULT_FE_TIMEOUT_EN
    ,
    .timeout          (timeout)
`endif
  );

  // Sequential multiplier model: ready low for N cycles after start, product appears with ready
  bit         hang = 1'b0;
  int         mcnt;
  logic [7:0] ma;
  logic [7:0] mb;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mul_ready   <= 1'b1;
      mul_product <= 8'h00;
      mcnt        <= 0;
      ma          <= 8'h00;
      mb          <= 8'h00;
    end else if (mul_ready && mul_start) begin
      mul_ready   <= 1'b0;
      mul_product <= 8'h00;
      mcnt        <= N;
      ma          <= {4'h0, mul_multiplicand};
      mb          <= {4'h0, mul_multiplier};
    end else if (!mul_ready && !hang) begin
      if (mcnt == 1) begin
        mul_ready   <= 1'b1;
        mul_product <= ma * mb;
      end
      mcnt <= mcnt - 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_pair(input logic [3:0] a, input logic [3:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mul_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_valid(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Expects out_ready=1; waits for a result, compares it and consumes it
  task automatic collect(input string name, input logic [7:0] exp);
    bit seen;
    wait_valid(seen);
    if (seen) begin
      chk(name, out_product, exp);
      tick();
    end else begin
      chk({name, "_wait"}, 32'd0, 32'd1);
    end
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit seen;
    int lat;
    int starts;
    int valids;

    vecs[0] = '{a: 4'd3,  b: 4'd5,  p: 8'h0F};
    vecs[1] = '{a: 4'd15, b: 4'd15, p: 8'hE1};
    vecs[2] = '{a: 4'd0,  b: 4'd9,  p: 8'h00};
    vecs[3] = '{a: 4'd7,  b: 4'd6,  p: 8'h2A};
    vecs[4] = '{a: 4'd12, b: 4'd11, p: 8'h84};
    vecs[5] = '{a: 4'd1,  b: 4'd15, p: 8'h0F};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = 4'h0;
    in_b      = 4'h0;
    out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_out_product", out_product, 8'h00);

    // Single operations: latency, product and one-cycle valid
    out_ready = 1'b1;
    foreach (vecs[v]) begin
      push_pair(vecs[v].a, vecs[v].b);
      wait_start(seen);
      chk($sformatf("v%0d_start", v), seen, 1);
      lat    = 0;
      starts = 0;
      for (int k = 1; k <= 30; k++) begin
        tick();
        if (k == 1) chk($sformatf("v%0d_busy", v), busy, 1);
        if (mul_start) starts++;
        if (out_valid) begin
          lat = k;
          break;
        end
      end
      chk($sformatf("v%0d_latency", v), lat, N + 2);
      chk($sformatf("v%0d_product", v), out_product, vecs[v].p);
      chk($sformatf("v%0d_extra_start", v), starts, 0);
      tick();
      chk($sformatf("v%0d_valid_pulse", v), out_valid, 0);
      chk($sformatf("v%0d_idle", v), busy, 0);
    end

    // Back-pressure: five consecutive pushes, first result held
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_a     = 4'(i + 1);
      in_b     = 4'(i + 2);
      chk($sformatf("bp_in_ready%0d", i), in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    chk("bp_count_full", fifo_count, 4);
    chk("bp_in_ready_full", in_ready, 0);
    push_pair(4'd9, 4'd9);
    push_pair(4'd9, 4'd9);
    chk("bp_full_ignore", fifo_count, 4);
    wait_valid(seen);
    chk("bp_first_valid", seen, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_hold_valid%0d", i), out_valid, 1);
      chk($sformatf("bp_hold_prod%0d", i), out_product, 8'h02);
      tick();
    end
    out_ready = 1'b1;
    collect("bp_r0", 8'h02);
    collect("bp_r1", 8'h06);
    collect("bp_r2", 8'h0C);
    collect("bp_r3", 8'h14);
    collect("bp_r4", 8'h1E);
    chk("bp_drained", fifo_count, 0);

    // Push in the same cycle as the IDLE issue pop
    out_ready = 1'b0;
    push_pair(4'd2, 4'd2);
    wait_start(seen);
    tick();
    push_pair(4'd3, 4'd3);
    push_pair(4'd4, 4'd4);
    chk("pp_pre_count", fifo_count, 2);
    wait_valid(seen);
    chk("pp_first_prod", out_product, 8'h04);
    out_ready = 1'b1;
    tick();
    chk("pp_issue", mul_start, 1);
    chk("pp_issue_count", fifo_count, 2);
    push_pair(4'd5, 4'd5);
    chk("pp_same_cycle", fifo_count, 2);
    collect("pp_r1", 8'h09);
    collect("pp_r2", 8'h10);
    collect("pp_r3", 8'h19);
    chk("pp_drained", fifo_count, 0);

    // Reset two cycles into a multiply
    push_pair(4'd6, 4'd7);
    wait_start(seen);
    tick();
    push_pair(4'd1, 4'd1);
    chk("rb_pre_count", fifo_count, 1);
    reset = 1'b1;
    #1;
    chk("rb_out_valid", out_valid, 0);
    chk("rb_fifo_count", fifo_count, 0);
    chk("rb_in_ready", in_ready, 1);
    chk("rb_busy", busy, 0);
    tick();
    reset = 1'b0;
    valids = 0;
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) valids++;
      if (mul_start) starts++;
    end
    chk("rb_no_stale_valid", valids, 0);
    chk("rb_no_start", starts, 0);

`ifdef SEQ_MULT_FE_TIMEOUT_EN
    // Hung multiplier: timeout result visible after 12 BUSY cycles
    hang      = 1'b1;
    out_ready = 1'b0;
    push_pair(4'd2, 4'd3);
    wait_start(seen);
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (timeout) begin
        lat = k;
        break;
      end
    end
    chk("to_cycle", lat, 13);
    chk("to_valid", out_valid, 1);
    chk("to_product", out_product, 8'hFF);
    tick();
    chk("to_pulse", timeout, 0);
    chk("to_hold", out_valid, 1);
    reset = 1'b1;
    tick();
    hang  = 1'b0;
    reset = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
